// File: rtl/jtkicker_colmix_if.sv
// PROM download bus for the Kicker colour mixer.
// The loader drives the address, data and write strobe. The mixer only receives them.
interface jtkicker_colmix_if;
    logic [8:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_en;

    modport master (output prog_addr, output prog_data, output prog_en);
    modport slave  (input  prog_addr, input  prog_data, input  prog_en);
endinterface

// File: rtl/jtkicker_colmix.sv
// Kicker final colour mixer. It merges the object pixel with the char pixel, translates the
// char colour through the lookup PROM and maps the result through the RGB palette PROM.
module jtkicker_colmix #(
    parameter string SIMFILE_LUT = "",
    parameter string SIMFILE_PAL = ""
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pxl_cen,
    input  logic                    LHBL,
    input  logic                    LVBL,
    input  logic [3:0]              obj_pxl,
    input  logic [3:0]              scr_pxl,
    input  logic [3:0]              scr_pal,
    input  logic                    scr_prio,
    input  logic [3:0]              gfx_en,
    jtkicker_colmix_if.slave        prog,
    output logic [2:0]              red,
    output logic [2:0]              green,
    output logic [1:0]              blue,
    output logic                    LHBL_dly,
    output logic                    LVBL_dly
);
    // The preload files only matter to simulation models. Layers 1 and 2 do not exist on this board.
    localparam bit unused_simfile = (SIMFILE_LUT != "") || (SIMFILE_PAL != "");
    logic unused_gfx;
    assign unused_gfx = ^gfx_en[2:1];

    logic [3:0] lut_mem [0:255];
    logic [7:0] pal_mem [0:31];

    always_ff @(posedge clk) begin
        if (prog.prog_en) begin
            if (!prog.prog_addr[8])
                lut_mem[prog.prog_addr[7:0]] <= prog.prog_data[3:0];
            else if (prog.prog_addr[7:5] == 3'd0)
                pal_mem[prog.prog_addr[4:0]] <= prog.prog_data;
        end
    end

    logic [3:0] obj_s1;
    logic       prio_s1;
    logic [3:0] lut_rd;
    logic [4:0] pal_idx;
    logic [2:0] hb_sr;
    logic [2:0] vb_sr;
    logic [3:0] lut_q;
    logic       obj_win;

    always_comb begin
        lut_q   = gfx_en[0] ? lut_rd : 4'd0;
        obj_win = (obj_s1 != 4'd0) && !(prio_s1 && (lut_q != 4'd0));
    end

    // The blank state moving into stage 3 gates the palette read, so RGB and the delayed blanks change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            obj_s1  <= 4'd0;
            prio_s1 <= 1'b0;
            lut_rd  <= 4'd0;
            pal_idx <= 5'd0;
            hb_sr   <= 3'd0;
            vb_sr   <= 3'd0;
            red     <= 3'd0;
            green   <= 3'd0;
            blue    <= 2'd0;
        end else if (pxl_cen) begin
            obj_s1  <= gfx_en[3] ? obj_pxl : 4'd0;
            prio_s1 <= scr_prio;
            lut_rd  <= lut_mem[{scr_pal, scr_pxl}];
            pal_idx <= obj_win ? {1'b1, obj_s1} : {1'b0, lut_q};
            hb_sr   <= {hb_sr[1:0], LHBL};
            vb_sr   <= {vb_sr[1:0], LVBL};
            if (hb_sr[1] && vb_sr[1])
                {blue, green, red} <= pal_mem[pal_idx];
            else
                {blue, green, red} <= 8'd0;
        end
    end

    assign LHBL_dly = hb_sr[2];
    assign LVBL_dly = vb_sr[2];
endmodule

// File: tb/tb_jtkicker_colmix.sv
// Self-checking bench for jtkicker_colmix: directed scenarios plus a randomized run against a rule-level model.
module tb_jtkicker_colmix;
    logic       clk = 1'b0;
    logic       rst, pxl_cen, LHBL, LVBL, scr_prio;
    logic [3:0] obj_pxl, scr_pxl, scr_pal, gfx_en;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       LHBL_dly, LVBL_dly;
    logic       cen_run = 1'b1;
    logic [7:0] cen_cnt = 8'd0;
    int         checks = 0;
    int         failures = 0;

    logic [3:0]  lut_m [0:255];
    logic [7:0]  pal_m [0:31];
    logic [9:0]  expq [$];

    jtkicker_colmix_if prog_bus();

    jtkicker_colmix dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .obj_pxl(obj_pxl), .scr_pxl(scr_pxl), .scr_pal(scr_pal), .scr_prio(scr_prio),
        .gfx_en(gfx_en), .prog(prog_bus.slave), .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cen_cnt = cen_cnt + 8'd1;
        pxl_cen = cen_run && (cen_cnt[1:0] == 2'd0);
    end

    task automatic tick();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!pxl_cen && n < 100);
        #1;
    endtask

    task automatic prom_wr(input logic [8:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        prog_bus.prog_addr = a;
        prog_bus.prog_data = d;
        prog_bus.prog_en   = 1'b1;
        @(posedge clk); #1;
        prog_bus.prog_en   = 1'b0;
        if (a < 9'h100)      lut_m[a[7:0]] = d[3:0];
        else if (a < 9'h120) pal_m[a - 9'h100] = d;
    endtask

    // Returns {LHBL_dly, LVBL_dly, blue, green, red} that the given input pixel should produce.
    function automatic logic [9:0] model(input logic [3:0] o_in, input logic [3:0] pxl,
                                         input logic [3:0] pl, input logic pr, input logic [3:0] g,
                                         input logic hb, input logic vb);
        int o, l, idx;
        logic [7:0] c;
        o = g[3] ? int'(o_in) : 0;
        l = g[0] ? int'(lut_m[pl * 16 + pxl]) : 0;
        if (o != 0 && !(pr && l != 0)) idx = 16 + o;
        else                           idx = l;
        c = (hb && vb) ? pal_m[idx] : 8'd0;
        return {hb, vb, c[7:6], c[5:3], c[2:0]};
    endfunction

    task automatic set_char(input logic [3:0] o, input logic pr, input logic [3:0] g);
        scr_pal = 4'h3; scr_pxl = 4'h5; obj_pxl = o; scr_prio = pr; gfx_en = g;
        LHBL = 1'b1; LVBL = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({red, green, blue, LHBL_dly, LVBL_dly} !== 10'd0) begin
                failures++;
                $display("FAIL reset_hold clk=%0d got=%h want=0", i, {red, green, blue, LHBL_dly, LVBL_dly});
            end
        end
        set_char(4'h0, 1'b0, 4'hF);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({LHBL_dly, LVBL_dly} !== ((i == 3) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL reset_release cen=%0d got=%b want=%b", i, {LHBL_dly, LVBL_dly}, (i == 3) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] e;
        for (int p = 0; p < 4; p++) begin
            gfx_en = (p == 0) ? 4'hF : 4'($urandom);
            expq.delete();
            for (int i = 0; i < 80; i++) begin
                obj_pxl  = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
                scr_pxl  = 4'($urandom);
                scr_pal  = 4'($urandom);
                scr_prio = 1'($urandom);
                LHBL     = ($urandom % 8) != 0;
                LVBL     = ($urandom % 8) != 0;
                tick();
                expq.push_back(model(obj_pxl, scr_pxl, scr_pal, scr_prio, gfx_en, LHBL, LVBL));
                if (expq.size() == 3) begin
                    e = expq.pop_front();
                    checks++;
                    if ({blue, green, red} !== e[7:0]) begin
                        failures++;
                        $display("FAIL random_rgb phase=%0d px=%0d got=%h want=%h", p, i, {blue, green, red}, e[7:0]);
                    end
                    checks++;
                    if ({LHBL_dly, LVBL_dly} !== e[9:8]) begin
                        failures++;
                        $display("FAIL random_blank phase=%0d px=%0d got=%b want=%b", p, i, {LHBL_dly, LVBL_dly}, e[9:8]);
                    end
                end
            end
        end
    endtask

    task automatic test_priority();
        prom_wr(9'h035, 8'h07);
        prom_wr(9'h107, 8'hA5);
        prom_wr(9'h119, 8'hFF);
        set_char(4'h0, 1'b0, 4'hF);
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd5, 3'd4, 2'd2}) begin
            failures++;
            $display("FAIL transparency got=%h want=%h", {red, green, blue}, {3'd5, 3'd4, 2'd2});
        end
        set_char(4'h9, 1'b0, 4'hF);
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd7, 3'd7, 2'd3}) begin
            failures++;
            $display("FAIL obj_over_char got=%h want=%h", {red, green, blue}, {3'd7, 3'd7, 2'd3});
        end
        set_char(4'h9, 1'b1, 4'hF);
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd5, 3'd4, 2'd2}) begin
            failures++;
            $display("FAIL char_prio got=%h want=%h", {red, green, blue}, {3'd5, 3'd4, 2'd2});
        end
        prom_wr(9'h035, 8'h00);
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd7, 3'd7, 2'd3}) begin
            failures++;
            $display("FAIL prio_transparent_char got=%h want=%h", {red, green, blue}, {3'd7, 3'd7, 2'd3});
        end
    endtask

    task automatic test_blanking();
        logic hist [0:39];
        logic exp_b;
        for (int m = 0; m < 2; m++) begin
            set_char(4'h9, 1'b0, 4'hF);
            repeat (3) tick();
            for (int j = 0; j < 30; j++) begin
                hist[j] = !(j >= 5 && j < 15);
                if (m == 0) LHBL = hist[j]; else LVBL = hist[j];
                tick();
                exp_b = (j >= 2) ? hist[j - 2] : 1'b1;
                checks++;
                if (((m == 0) ? LHBL_dly : LVBL_dly) !== exp_b) begin
                    failures++;
                    $display("FAIL blank_dly sig=%0d px=%0d got=%b want=%b", m, j, (m == 0) ? LHBL_dly : LVBL_dly, exp_b);
                end
                checks++;
                if ({red, green, blue} !== (exp_b ? {3'd7, 3'd7, 2'd3} : 8'd0)) begin
                    failures++;
                    $display("FAIL blank_rgb sig=%0d px=%0d got=%h want=%h", m, j, {red, green, blue}, exp_b ? {3'd7, 3'd7, 2'd3} : 8'd0);
                end
            end
        end
    endtask

    task automatic test_download();
        prom_wr(9'h020, 8'h03);
        prom_wr(9'h103, 8'h5A);
        prom_wr(9'h100, 8'hC3);
        prom_wr(9'h120, 8'h00);
        scr_pal = 4'h2; scr_pxl = 4'h0; obj_pxl = 4'h0; scr_prio = 1'b0; gfx_en = 4'hF;
        LHBL = 1'b1; LVBL = 1'b1;
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd2, 3'd3, 2'd1}) begin
            failures++;
            $display("FAIL dl_ignore_lut got=%h want=%h", {red, green, blue}, {3'd2, 3'd3, 2'd1});
        end
        gfx_en = 4'b1000;
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd3, 3'd0, 2'd3}) begin
            failures++;
            $display("FAIL dl_ignore_pal got=%h want=%h", {red, green, blue}, {3'd3, 3'd0, 2'd3});
        end
        prom_wr(9'h11F, 8'h12);
        obj_pxl = 4'hF; gfx_en = 4'hF;
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd2, 3'd2, 2'd0}) begin
            failures++;
            $display("FAIL dl_last_pal got=%h want=%h", {red, green, blue}, {3'd2, 3'd2, 2'd0});
        end
    endtask

    task automatic test_gfx_en();
        prom_wr(9'h035, 8'h07);
        set_char(4'h9, 1'b0, 4'b0001);
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd5, 3'd4, 2'd2}) begin
            failures++;
            $display("FAIL gfx_obj_off got=%h want=%h", {red, green, blue}, {3'd5, 3'd4, 2'd2});
        end
        set_char(4'h0, 1'b0, 4'b1000);
        repeat (3) tick();
        checks++;
        if ({red, green, blue} !== {3'd3, 3'd0, 2'd3}) begin
            failures++;
            $display("FAIL gfx_char_off got=%h want=%h", {red, green, blue}, {3'd3, 3'd0, 2'd3});
        end
    endtask

    task automatic test_freeze_and_midline_reset();
        set_char(4'h0, 1'b0, 4'hF);
        repeat (3) tick();
        cen_run = 1'b0;
        obj_pxl = 4'h9; LHBL = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if ({red, green, blue, LHBL_dly, LVBL_dly} !== {3'd5, 3'd4, 2'd2, 2'b11}) begin
            failures++;
            $display("FAIL freeze got=%h want=%h", {red, green, blue, LHBL_dly, LVBL_dly}, {3'd5, 3'd4, 2'd2, 2'b11});
        end
        cen_run = 1'b1;
        set_char(4'h0, 1'b0, 4'hF);
        repeat (3) tick();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({red, green, blue, LHBL_dly, LVBL_dly} !== 10'd0) begin
            failures++;
            $display("FAIL midline_reset got=%h want=0", {red, green, blue, LHBL_dly, LVBL_dly});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({red, green, blue, LHBL_dly, LVBL_dly} !== ((i == 3) ? {3'd5, 3'd4, 2'd2, 2'b11} : 10'd0)) begin
                failures++;
                $display("FAIL reset_resume cen=%0d got=%h want=%h", i, {red, green, blue, LHBL_dly, LVBL_dly},
                         (i == 3) ? {3'd5, 3'd4, 2'd2, 2'b11} : 10'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        prog_bus.prog_addr = 9'd0; prog_bus.prog_data = 8'd0; prog_bus.prog_en = 1'b0;
        set_char(4'h0, 1'b0, 4'hF);
        LHBL = 1'b0; LVBL = 1'b0;
        for (int a = 0; a < 9'h120; a++) prom_wr(9'(a), 8'($urandom));
        test_reset();
        test_random();
        test_priority();
        test_blanking();
        test_download();
        test_gfx_en();
        test_freeze_and_midline_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
